// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
// FSM states, requester ids and the bus width.
package mem_arb_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    FETCH,
    DATA
  } src_e;

endpackage

// File: rtl/mem_arb_timeout.sv
// Bus-wait watchdog: counts BUSY cycles and flags expiry.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Fires on the last permitted BUSY cycle so the drop is registered.
  assign expired_o = run_i &&
    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (run_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between fetch and data requesters.
// Define ARB_TIMEOUT_EN to abort bus transactions that never ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_STREAK    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [BUS_W-1:0] if_addr,
  output logic             if_valid,
  output logic [BUS_W-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [BUS_W-1:0] dm_addr,
  input  logic [BUS_W-1:0] dm_wdata,
  output logic             dm_valid,
  output logic [BUS_W-1:0] dm_rdata,
  output logic             stall_if,
  output logic             stall_mem,
  output logic             bus_req,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [BUS_W-1:0] bus_rdata,
  output logic             bus_err
);

  if (DATA_STREAK < 1 || DATA_STREAK > 15 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: bad parameters");
  end

  state_e           state_q;
  src_e             src_q;
  logic [3:0]       streak_q;
  logic             if_valid_q;
  logic             dm_valid_q;
  logic [BUS_W-1:0] if_rdata_q;
  logic [BUS_W-1:0] dm_rdata_q;
  logic             bus_req_q;
  logic             bus_we_q;
  logic [BUS_W-1:0] bus_addr_q;
  logic [BUS_W-1:0] bus_wdata_q;
  logic             bus_err_q;

  logic at_limit;
  logic pick_data;
  logic grant;
  logic expired;

  assign at_limit  = (streak_q == 4'(DATA_STREAK));
  assign pick_data = dm_req && !(if_req && at_limit);
  assign grant     = (state_q == IDLE) &&
                     (if_req || dm_req);

`ifdef ARB_TIMEOUT_EN
  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (grant),
    .run_i    (state_q == BUSY),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= FETCH;
      streak_q    <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!if_req) streak_q <= '0;
          if (grant) begin
            bus_req_q <= 1'b1;
            state_q   <= BUSY;
            if (pick_data) begin
              src_q       <= DATA;
              bus_we_q    <= dm_we;
              bus_addr_q  <= dm_addr;
              bus_wdata_q <= dm_wdata;
              // pick_data excludes if_req at the limit.
              if (if_req) streak_q <= streak_q + 4'd1;
            end else begin
              src_q       <= FETCH;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= if_addr;
              bus_wdata_q <= '0;
              streak_q    <= '0;
            end
          end
        end
        BUSY: begin
          if (bus_ack || expired) begin
            bus_req_q <= 1'b0;
            bus_err_q <= !bus_ack;
            state_q   <= RESP;
            if (src_q == DATA) begin
              dm_valid_q <= 1'b1;
              dm_rdata_q <= (bus_ack && !bus_we_q) ?
                            bus_rdata : '0;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= bus_ack ? bus_rdata : '0;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;

endmodule
